// File: rtl/parity_rx.sv
// Serial frame receiver: deserializes start/data/parity/stop frames sampled on a
// bit strobe, flags parity and framing errors, and counts parity errors.
module parity_rx #(
  parameter int DATA_BITS  = 8,
  parameter int ODD_PARITY = 0,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 led
);

  localparam int                   IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX  = {ERR_CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t               state_r;
  logic [DATA_BITS-1:0] shift_r;
  logic [IDX_W-1:0]     idx_r;
  logic                 par_r;
  logic                 armed_r;
  logic                 stb_s;
  logic                 fail_s;

  function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
    return ((^d) ^ p) != ODD_PARITY[0];
  endfunction

  // armed_r masks the strobe on the first edge after reset release
  always_comb begin
    stb_s  = bit_valid & armed_r;
    fail_s = parity_bad(shift_r, par_r);
  end

  // Frame state machine with registered status outputs
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_r    <= IDLE;
      shift_r    <= '0;
      idx_r      <= '0;
      par_r      <= 1'b0;
      armed_r    <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      err_count  <= '0;
      led        <= 1'b0;
    end else begin
      armed_r    <= 1'b1;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (stb_s) begin
        case (state_r)
          IDLE: begin
            if (!bit_in) begin
              state_r <= DATA;
              idx_r   <= '0;
            end
          end
          DATA: begin
            shift_r[idx_r] <= bit_in;
            idx_r          <= idx_r + IDX_W'(1);
            if (idx_r == LAST_IDX) begin
              state_r <= PARITY;
            end
          end
          PARITY: begin
            par_r   <= bit_in;
            state_r <= STOP;
          end
          STOP: begin
            state_r <= IDLE;
            if (bit_in) begin
              data_out   <= shift_r;
              data_valid <= 1'b1;
              if (fail_s) begin
                parity_err <= 1'b1;
                led        <= 1'b1;
                if (err_count != CNT_MAX) begin
                  err_count <= err_count + ERR_CNT_W'(1);
                end
              end
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state_r <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_parity_rx.sv
// Scoreboard bench for parity_rx: directed frames push expected pulses into a
// queue; per-instance monitors pop and compare whenever a pulse appears.
module tb_parity_rx;

  typedef struct {
    logic [7:0] data;
    logic       dv;
    logic       pe;
    logic       fe;
    logic [7:0] cnt;
    logic       led;
    time        t;
  } exp_t;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       bv0 = 1'b0, bi0 = 1'b1, bv1 = 1'b0, bi1 = 1'b1;
  logic [7:0] dout0, dout1;
  logic       dv0, pe0, fe0, led0, dv1, pe1, fe1, led1;
  logic [7:0] cnt0;
  logic [1:0] cnt1;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [7:0] m_dout[2];
  logic [7:0] m_cnt[2];
  logic       m_led[2];
  logic [7:0] m_max[2];
  int         n_vec = 0;
  int         n_bad = 0;

  parity_rx #(.DATA_BITS(8), .ODD_PARITY(0), .ERR_CNT_W(8)) u_even (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .bit_valid(bv0), .bit_in(bi0),
    .data_out(dout0), .data_valid(dv0), .parity_err(pe0), .frame_err(fe0),
    .err_count(cnt0), .led(led0));

  parity_rx #(.DATA_BITS(8), .ODD_PARITY(1), .ERR_CNT_W(2)) u_odd (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .bit_valid(bv1), .bit_in(bi1),
    .data_out(dout1), .data_valid(dv1), .parity_err(pe1), .frame_err(fe1),
    .err_count(cnt1), .led(led1));

  always #5 sys_clk = ~sys_clk;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_event(input int inst, input logic [7:0] d, input logic dv,
                             input logic pe, input logic fe, input logic [7:0] c,
                             input logic l);
    exp_t e;
    n_vec++;
    if ((inst == 0 && q0.size() == 0) || (inst == 1 && q1.size() == 0)) begin
      n_bad++;
      $display("FAIL unexpected_pulse inst%0d: dv=%b pe=%b fe=%b at %0t", inst, dv, pe, fe, $time);
    end else begin
      if (inst == 0) e = q0.pop_front();
      else           e = q1.pop_front();
      if ({d, dv, pe, fe, c, l} !== {e.data, e.dv, e.pe, e.fe, e.cnt, e.led}) begin
        n_bad++;
        $display("FAIL event inst%0d: got data=%h dv=%b pe=%b fe=%b cnt=%0d led=%b, expected data=%h dv=%b pe=%b fe=%b cnt=%0d led=%b",
                 inst, d, dv, pe, fe, c, l, e.data, e.dv, e.pe, e.fe, e.cnt, e.led);
      end
      compare($sformatf("latency_inst%0d", inst), 32'($time), 32'(e.t));
    end
  endtask

  // Monitors: sample outputs on the falling edge, away from the active edge
  always @(negedge sys_clk) begin
    if (!sys_rst && (dv0 || pe0 || fe0)) check_event(0, dout0, dv0, pe0, fe0, cnt0, led0);
  end

  always @(negedge sys_clk) begin
    if (!sys_rst && (dv1 || pe1 || fe1)) check_event(1, dout1, dv1, pe1, fe1, {6'd0, cnt1}, led1);
  end

  task automatic drive(input int inst, input logic v, input logic b);
    if (inst == 0) begin bv0 = v; bi0 = b; end
    else           begin bv1 = v; bi1 = b; end
  endtask

  task automatic strobe(input int inst, input logic b, input int gap);
    for (int i = 0; i < gap; i++) begin
      @(negedge sys_clk);
      drive(inst, 1'b0, 1'($urandom_range(0, 1)));
    end
    @(negedge sys_clk);
    drive(inst, 1'b1, b);
  endtask

  task automatic idle(input int inst);
    @(negedge sys_clk);
    drive(inst, 1'b0, 1'b1);
  endtask

  task automatic send_frame(input int inst, input logic [7:0] d, input logic p,
                            input logic stop, input int gap, input logic exp_pe);
    exp_t e;
    strobe(inst, 1'b0, gap);
    for (int i = 0; i < 8; i++) strobe(inst, d[i], gap);
    strobe(inst, p, gap);
    strobe(inst, stop, gap);
    if (stop) begin
      m_dout[inst] = d;
      if (exp_pe) begin
        m_led[inst] = 1'b1;
        if (m_cnt[inst] != m_max[inst]) m_cnt[inst] = m_cnt[inst] + 8'd1;
      end
    end
    e.data = m_dout[inst];
    e.dv   = stop;
    e.pe   = stop & exp_pe;
    e.fe   = ~stop;
    e.cnt  = m_cnt[inst];
    e.led  = m_led[inst];
    e.t    = $time + 10;
    if (inst == 0) q0.push_back(e);
    else           q1.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    compare({tag, "_inst0"}, {20'd0, dout0, dv0, pe0, fe0, led0},
            32'd0);
    compare({tag, "_cnt0"}, {24'd0, cnt0}, 32'd0);
    compare({tag, "_inst1"}, {18'd0, dout1, dv1, pe1, fe1, led1, cnt1}, 32'd0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_dout[i] = 8'h00;
      m_cnt[i]  = 8'd0;
      m_led[i]  = 1'b0;
    end
  endtask

  initial begin
    int budget;
    model_reset();
    m_max[0] = 8'hFF;
    m_max[1] = 8'h03;
    repeat (3) @(negedge sys_clk);
    check_zero("reset");
    sys_rst = 1'b0;
    idle(0);

    // Good A5, bad-parity A5, good 3C, back-to-back, strobe every clock
    send_frame(0, 8'hA5, 1'b0, 1'b1, 0, 1'b0);
    send_frame(0, 8'hA5, 1'b1, 1'b1, 0, 1'b1);
    send_frame(0, 8'h3C, 1'b0, 1'b1, 0, 1'b0);
    // Framing error: data_out must keep 3C
    send_frame(0, 8'h0F, 1'b0, 1'b0, 0, 1'b0);
    idle(0);
    // Strobe every 5 clocks with line noise between strobes
    send_frame(0, 8'hA5, 1'b0, 1'b1, 4, 1'b0);
    idle(0);
    repeat (3) idle(0);

    // Reset after 4 data bits of a frame
    strobe(0, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      strobe(0, i[0], 0);
    end
    @(negedge sys_clk);
    sys_rst = 1'b1;
    drive(0, 1'b0, 1'b1);
    @(negedge sys_clk);
    check_zero("midreset");
    model_reset();
    // Release with a start-looking strobe in the same cycle; it must be ignored
    @(negedge sys_clk);
    sys_rst = 1'b0;
    drive(0, 1'b1, 1'b0);
    strobe(0, 1'b1, 0);
    send_frame(0, 8'h3C, 1'b0, 1'b1, 0, 1'b0);
    idle(0);

    // Odd parity, 2-bit counter: five bad frames back-to-back, saturate at 3
    idle(1);
    for (int k = 0; k < 5; k++) send_frame(1, 8'h01, 1'b1, 1'b1, 0, 1'b1);
    idle(1);

    budget = 0;
    while ((q0.size() != 0 || q1.size() != 0) && budget < 50) begin
      @(negedge sys_clk);
      budget++;
    end
    repeat (2) @(negedge sys_clk);
    compare("pending_inst0", 32'(q0.size()), 32'd0);
    compare("pending_inst1", 32'(q1.size()), 32'd0);
    compare("final_cnt1", {30'd0, cnt1}, 32'd3);
    compare("final_led1", {31'd0, led1}, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
